md5_block_padder: RTL and testbench

//  Upstream message-formatting stage for the MD5 round core. Takes a message as
//  a stream of 32-bit little-endian words and applies MD5 padding: a 0x80 byte,

---
 rtl/md5_block_padder.sv | 225 ++++++++++++++++++++++
 tb/tb_md5_block_padder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/md5_block_padder.sv
// MD5 message padder: packs 32-bit little-endian message words into 512-bit
// blocks, appends the 0x80 marker, zero fill and the 64-bit bit length, then
// hands each block to the round core as four 128-bit beats.
module md5_block_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    input  logic         core_ready,
    output logic         en1,
    output logic         en2,
    output logic         en3,
    output logic         en4,
    output logic [127:0] data_o,
    output logic         blk_last,
    output logic         busy
);

    typedef enum logic [2:0] {
        StFill, StPad, StHold, StEmit1, StEmit2, StEmit3, StEmit4, StPad2
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         idx_q, idx_d;      // 16 means the block is full
    logic [LEN_W-1:0]   cnt_q, cnt_d;      // message byte count
    logic [31:0]        mblk_q [16];
    logic [31:0]        mblk_d [16];
    logic               last_q, last_d;    // current block is the final one
    logic               pend_q, pend_d;    // a length-only block must follow
    logic               spill_q, spill_d;  // that block starts with the 0x80 word
    logic               pad80_q, pad80_d;  // 0x80 still owed as a separate word
    logic               busy_q, busy_d;
    logic [127:0]       hold_q, hold_d;    // last emitted beat, kept on data_o

    logic               accept;
    logic [2:0]         k;
    logic [31:0]        pad_word;
    logic [LEN_W-1:0]   bitlen;
    logic [63:0]        len64;
    logic [1:0]         beat_idx;
    logic [127:0]       beat;
    logic               emitting;

    // Last-word lane handling: keep the valid lanes, drop 0x80 into the first free lane.
    always_comb begin
        k = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        pad_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < k) begin
                pad_word[8*b +: 8] = in_data[8*b +: 8];
            end else if (3'(b) == k) begin
                pad_word[8*b +: 8] = 8'h80;
            end
        end
    end

    // Bit length (wraps at LEN_W bits) and beat assembly, M0 in the top word.
    always_comb begin
        bitlen = cnt_q << 3;
        len64 = '0;
        len64[LEN_W-1:0] = bitlen;
        beat = {mblk_q[{beat_idx, 2'd0}], mblk_q[{beat_idx, 2'd1}],
                mblk_q[{beat_idx, 2'd2}], mblk_q[{beat_idx, 2'd3}]};
    end

    // Next-state logic and beat strobes.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mblk_d   = mblk_q;
        last_d   = last_q;
        pend_d   = pend_q;
        spill_d  = spill_q;
        pad80_d  = pad80_q;
        busy_d   = busy_q;
        hold_d   = hold_q;
        in_ready = 1'b0;
        en1      = 1'b0;
        en2      = 1'b0;
        en3      = 1'b0;
        en4      = 1'b0;
        emitting = 1'b0;
        beat_idx = 2'd0;
        accept   = 1'b0;

        unique case (state_q)
            StFill: begin
                in_ready = reset;
                accept   = in_valid & reset;
                if (accept) begin
                    busy_d = 1'b1;
                    mblk_d[idx_q[3:0]] = pad_word;
                    if (in_last) begin
                        cnt_d   = cnt_q + LEN_W'(k);
                        pad80_d = (k == 3'd4);
                        // idx now points at the word holding (or owed) the 0x80
                        idx_d   = (k == 3'd4) ? idx_q + 5'd1 : idx_q;
                        state_d = StPad;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(4);
                        idx_d = idx_q + 5'd1;
                        if (idx_q == 5'd15) begin
                            last_d  = 1'b0;
                            state_d = StHold;
                        end
                    end
                end
            end
            StPad: begin
                if (idx_q <= 5'd13) begin
                    if (pad80_q) begin
                        mblk_d[idx_q[3:0]] = 32'h0000_0080;
                    end
                    mblk_d[14] = len64[31:0];
                    mblk_d[15] = len64[63:32];
                    last_d = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    // No room for the length: an owed 0x80 word moves to M0 of the next block.
                    last_d  = 1'b0;
                    pend_d  = 1'b1;
                    spill_d = pad80_q;
                end
                pad80_d = 1'b0;
                state_d = StHold;
            end
            StHold: begin
                if (core_ready) begin
                    state_d = StEmit1;
                end
            end
            StEmit1: begin
                en1 = 1'b1;
                emitting = 1'b1;
                beat_idx = 2'd0;
                hold_d = beat;
                state_d = StEmit2;
            end
            StEmit2: begin
                en2 = 1'b1;
                emitting = 1'b1;
                beat_idx = 2'd1;
                hold_d = beat;
                state_d = StEmit3;
            end
            StEmit3: begin
                en3 = 1'b1;
                emitting = 1'b1;
                beat_idx = 2'd2;
                hold_d = beat;
                state_d = StEmit4;
            end
            StEmit4: begin
                en4 = 1'b1;
                emitting = 1'b1;
                beat_idx = 2'd3;
                hold_d = beat;
                idx_d = '0;
                for (int i = 0; i < 16; i++) begin
                    mblk_d[i] = '0;
                end
                if (pend_q) begin
                    state_d = StPad2;
                end else begin
                    state_d = StFill;
                    if (last_q) begin
                        cnt_d  = '0;
                        busy_d = 1'b0;
                    end
                end
            end
            StPad2: begin
                mblk_d[0]  = spill_q ? 32'h0000_0080 : 32'h0;
                mblk_d[14] = len64[31:0];
                mblk_d[15] = len64[63:32];
                last_d  = 1'b1;
                pend_d  = 1'b0;
                spill_d = 1'b0;
                state_d = StHold;
            end
        endcase
    end

    assign data_o   = emitting ? beat : hold_q;
    assign blk_last = emitting & last_q;
    assign busy     = busy_q;

    // State register; reset discards any partial message or block in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFill;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            spill_q <= 1'b0;
            pad80_q <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                mblk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            spill_q <= spill_d;
            pad80_q <= pad80_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            for (int i = 0; i < 16; i++) begin
                mblk_q[i] <= mblk_d[i];
            end
        end
    end

endmodule

// File: tb/tb_md5_block_padder.sv
// Directed bench for md5_block_padder: hand-computed padded blocks checked beat by beat.
module tb_md5_block_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         core_ready;
    logic         en1, en2, en3, en4;
    logic [127:0] data_o;
    logic         blk_last;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_m [16];

    md5_block_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .core_ready (core_ready),
        .en1        (en1),
        .en2        (en2),
        .en3        (en3),
        .en4        (en4),
        .data_o     (data_o),
        .blk_last   (blk_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] msg_word(input int i);
        return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    endfunction

    task automatic clear_m();
        for (int i = 0; i < 16; i++) exp_m[i] = 32'h0;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int w = 0;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready", {127'b0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_block(input string tag, input logic exp_last);
        int w = 0;
        logic [3:0] e;
        logic [127:0] b;
        while (!en1 && w < 60) begin
            tick();
            w++;
        end
        for (int n = 0; n < 4; n++) begin
            e = 4'b1000 >> n;
            b = {exp_m[4*n], exp_m[4*n+1], exp_m[4*n+2], exp_m[4*n+3]};
            chk({tag, "_en"}, {124'b0, en1, en2, en3, en4}, {124'b0, e});
            chk({tag, "_data"}, data_o, b);
            chk({tag, "_last"}, {127'b0, blk_last}, {127'b0, exp_last});
            tick();
        end
        b = {exp_m[12], exp_m[13], exp_m[14], exp_m[15]};
        chk({tag, "_en_off"}, {124'b0, en1, en2, en3, en4}, 128'd0);
        chk({tag, "_held"}, data_o, b);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_bytes = '0;
        core_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        chk("rst_en", {124'b0, en1, en2, en3, en4}, 128'd0);
        chk("rst_data", data_o, 128'd0);
        chk("rst_last", {127'b0, blk_last}, 128'd0);
        reset = 1'b1;
        tick();

        // Empty message.
        send(32'h0, 1'b1, 3'd0);
        clear_m();
        exp_m[0] = 32'h0000_0080;
        get_block("t1", 1'b1);
        chk("t1_busy", {127'b0, busy}, 128'd0);

        // "abc".
        send(32'h0063_6261, 1'b1, 3'd3);
        clear_m();
        exp_m[0] = 32'h8063_6261;
        exp_m[14] = 32'h18;
        get_block("t2", 1'b1);

        // "abcd" with in_bytes=7, treated as 4: 0x80 goes into M1.
        send(32'h6463_6261, 1'b1, 3'd7);
        clear_m();
        exp_m[0] = 32'h6463_6261;
        exp_m[1] = 32'h0000_0080;
        exp_m[14] = 32'h20;
        get_block("t7", 1'b1);

        // 56-byte message: length spills into a second block.
        for (int i = 0; i < 14; i++) begin
            send(msg_word(i), (i == 13), 3'd4);
            if (i == 0) chk("t3_busy", {127'b0, busy}, 128'd1);
        end
        clear_m();
        for (int i = 0; i < 14; i++) exp_m[i] = msg_word(i);
        get_block("t3a", 1'b0);
        chk("t3_busy_mid", {127'b0, busy}, 128'd1);
        clear_m();
        exp_m[0] = 32'h0000_0080;
        exp_m[14] = 32'h1C0;
        get_block("t3b", 1'b1);
        chk("t3_busy_end", {127'b0, busy}, 128'd0);

        // 64-byte message: pure data block, then the padding block.
        for (int i = 0; i < 16; i++) send(msg_word(i), (i == 15), 3'd4);
        clear_m();
        for (int i = 0; i < 16; i++) exp_m[i] = msg_word(i);
        get_block("t4a", 1'b0);
        clear_m();
        exp_m[0] = 32'h0000_0080;
        exp_m[14] = 32'h200;
        get_block("t4b", 1'b1);

        // Core not ready: block waits in HOLD.
        core_ready = 1'b0;
        send(32'h0063_6261, 1'b1, 3'd3);
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("t5_hold_en", {124'b0, en1, en2, en3, en4}, 128'd0);
            chk("t5_hold_rdy", {127'b0, in_ready}, 128'd0);
            tick();
        end
        core_ready = 1'b1;
        tick();
        chk("t5_en1_next", {127'b0, en1}, 128'd1);
        clear_m();
        exp_m[0] = 32'h8063_6261;
        exp_m[14] = 32'h18;
        get_block("t5", 1'b1);

        // Reset during EMIT2.
        send(32'h0063_6261, 1'b1, 3'd3);
        begin
            int w = 0;
            while (!en1 && w < 60) begin
                tick();
                w++;
            end
        end
        chk("t6_en1", {127'b0, en1}, 128'd1);
        tick();
        chk("t6_en2", {124'b0, en1, en2, en3, en4}, 128'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_en", {124'b0, en1, en2, en3, en4}, 128'd0);
        chk("t6_rst_data", data_o, 128'd0);
        chk("t6_rst_busy", {127'b0, busy}, 128'd0);
        chk("t6_rst_rdy", {127'b0, in_ready}, 128'd0);
        tick();
        tick();
        chk("t6_rst_quiet", {124'b0, en1, en2, en3, en4}, 128'd0);
        reset = 1'b1;
        tick();
        send(32'h0063_6261, 1'b1, 3'd3);
        get_block("t6", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
